ranger_sequencer: RTL
=====================

Name: ranger_sequencer

Overview:
- Sequences the ultrasonic distance sensor: starts each measurement, generates the trig pulse, times the echo width and converts it to centimetres.
- Stores each result in an 8-deep ring buffer and presents the newest and evicted-oldest samples to the averager.
- trig doubles as the averager's sample clock, so newest/oldest only change while trig is low and well before trig's next falling edge.

Parameters:
- CLK_PER_US, 40, clk cycles per microsecond tick
- TRIG_US, 10, trig high width in µs
- PERIOD_US, 60000, µs between successive trig rising edges
- ECHO_TIMEOUT_US, 30000, max µs for the echo rise wait and for the echo high width
- US_PER_CM, 58, echo µs per cm of distance
- DEPTH, 8, ring buffer depth (power of two)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  start new measurements while high
- echo  in  1  sensor echo, asynchronous
- trig  out  1  sensor trigger; also the averager's sample clock
- newest  out  12  most recent distance in cm
- oldest  out  12  sample evicted by the latest write (0 until the buffer is full)
- sample_valid  out  1  one-cycle pulse when newest/oldest update
- timeout  out  1  one-cycle pulse with sample_valid when the stored value came from a timeout
- full  out  1  DEPTH samples stored since reset

Behaviour:
- Reset (async, reset_n low):
  - trig, newest, oldest, sample_valid, timeout and full all go to 0.
  - All buffer entries, write pointer, fill count and counters clear; state goes to IDLE.
  - A reset mid-measurement abandons the measurement and stores nothing.
- Echo input: 2-flop synchroniser; edges are detected on the synchronised signal.
- µs tick:
  - Prescaler pulses tick once every CLK_PER_US clks.
  - The prescaler restarts at 0 on every state entry, so state durations are exact multiples of CLK_PER_US clks.
- Period counter:
  - Counts µs ticks from the last trig rising edge and saturates at PERIOD_US-1.
  - Clears to 0 on each IDLE->TRIG transition.
- State machine (decided to live in the shared package):
  - IDLE: trig=0. Go to TRIG when enable=1 and the period counter is at PERIOD_US-1. After reset the counter starts saturated, so the first trig begins 1 clk after enable is seen high.
  - TRIG: trig=1 for exactly TRIG_US*CLK_PER_US clks, then WAIT_RISE. Echo is ignored in this state.
  - WAIT_RISE: wait for a synchronised echo rising edge, then MEASURE. An echo level already high on entry is not an edge. After ECHO_TIMEOUT_US ticks with no rise, go to STORE with dist=12'hFFF and the timeout flag set.
  - MEASURE: the cm counter increments once every US_PER_CM ticks of echo high, i.e. dist=floor(echo_us/US_PER_CM), saturating at 4095. An echo falling edge goes to STORE. If echo is still high after ECHO_TIMEOUT_US ticks, go to STORE with dist=12'hFFF and timeout set.
  - STORE (1 clk):
    - oldest <= buf[wr_ptr] (pre-write value); newest <= dist.
    - buf[wr_ptr] <= dist; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
    - Fill count increments, saturating at DEPTH; full=1 once the count reaches DEPTH.
    - sample_valid=1 (and timeout if flagged) for this clk only; then IDLE.
- enable falling mid-measurement: the current measurement completes and is stored; no new trig is issued.
- enable rising while the period has not elapsed: no early trig.
- Stability contract: newest/oldest are constant from the STORE cycle through the following trig falling edge.
- Parameter legality: PERIOD_US > TRIG_US + 2*ECHO_TIMEOUT_US. Checked by an elaboration-time assertion.

Decomposition:
- Package ranger_pkg:
  - state enum {IDLE, TRIG, WAIT_RISE, MEASURE, STORE}
  - DIST_W=12
  - DIST_TIMEOUT=12'hFFF
- Sub-module dist_ring_buffer (DEPTH x DIST_W):
  - Owns buffer, wr_ptr and fill count.
  - Interface: write strobe + data in; evicted data, full flag out.

Test Plan:
- Use CLK_PER_US=1, TRIG_US=10, PERIOD_US=200, ECHO_TIMEOUT_US=80, US_PER_CM=5 unless stated.
- Reset, enable=1: trig high exactly 10 clks starting 1 clk after enable. Echo high 50 µs -> sample_valid pulse, newest=10, oldest=0, timeout=0.
- Nine measurements with echo widths 5,10,...,45 µs -> newest=1..9; full rises on the 8th STORE; 9th STORE gives oldest=1 (first sample). Trig rising edges are exactly 200 clks apart.
- Echo never rises -> after 80 µs in WAIT_RISE, newest=4095 and timeout pulses together with sample_valid.
- Echo stuck high from before trig -> no MEASURE entry; stored value 4095 with timeout.
- Echo high 79 µs -> newest=15 (floor). Echo high ≥80 µs -> newest=4095 with timeout.
- reset_n low during MEASURE -> outputs 0 immediately, no sample_valid. The next measurement's oldest=0 and full=0.

Source files
------------

// File: rtl/ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger sequencer.
package ranger_pkg;

  localparam int unsigned DIST_W = 12;

  // Stored in place of a distance when the echo wait or echo width timed out.
  localparam logic [DIST_W-1:0] DIST_TIMEOUT = 12'hFFF;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StStore
  } state_e;

endpackage

// File: rtl/dist_ring_buffer.sv
// DEPTH-entry ring of distance samples; returns the entry a write is about to evict.
module dist_ring_buffer
  import ranger_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [DIST_W-1:0] data_i,
  output logic [DIST_W-1:0] evicted_o,
  output logic              full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [DIST_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;

  // Pre-write contents at the write pointer; valid in the same cycle as wr_i.
  assign evicted_o = mem_q[wr_ptr_q];
  assign full_o    = (count_q == CntW'(DEPTH));

  // Storage, pointer (wraps naturally, DEPTH is a power of two) and saturating fill count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_i) begin
      mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      if (count_q != CntW'(DEPTH)) begin
        count_q <= count_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/ranger_sequencer.sv
// Ultrasonic ranger: trig generation, echo timing, cm conversion and sample history.
module ranger_sequencer
  import ranger_pkg::*;
#(
  parameter int unsigned CLK_PER_US      = 40,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned PERIOD_US       = 60000,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned US_PER_CM       = 58,
  parameter int unsigned DEPTH           = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] newest,
  output logic [DIST_W-1:0] oldest,
  output logic              sample_valid,
  output logic              timeout,
  output logic              full
);

  localparam int unsigned PcW = $clog2(CLK_PER_US + 1);
  localparam int unsigned PrW = $clog2(PERIOD_US);
  localparam int unsigned TmW = $clog2(TRIG_US + ECHO_TIMEOUT_US + 1);
  localparam int unsigned SbW = $clog2(US_PER_CM + 1);

  if (PERIOD_US <= TRIG_US + 2 * ECHO_TIMEOUT_US) begin : g_bad_period
    $error("PERIOD_US must exceed TRIG_US + 2*ECHO_TIMEOUT_US");
  end

  state_e            state_q, state_d;
  logic [PcW-1:0]    presc_q, presc_d;
  logic [TmW-1:0]    timer_q, timer_d;
  logic [PrW-1:0]    period_q, period_d;
  logic [SbW-1:0]    sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              to_q, to_d;
  logic              echo_meta_q, echo_sync_q, echo_prev_q;
  logic              trig_q, valid_q, timeout_q;
  logic [DIST_W-1:0] newest_q, oldest_q, evicted;
  logic              tick, state_change, echo_rise, echo_fall, store_en;

  assign tick      = (presc_q == PcW'(CLK_PER_US - 1));
  assign echo_rise = echo_sync_q & ~echo_prev_q;
  assign echo_fall = ~echo_sync_q & echo_prev_q;
  assign store_en  = (state_d == StStore);

  assign trig         = trig_q;
  assign newest       = newest_q;
  assign oldest       = oldest_q;
  assign sample_valid = valid_q;
  assign timeout      = timeout_q;

  // Echo synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
    end
  end

  // Next state, cm accumulation and timeout capture.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (enable && (period_q == PrW'(PERIOD_US - 1))) begin
          state_d = StTrig;
          sub_d   = '0;
          cm_d    = '0;
          to_d    = 1'b0;
        end
      end
      StTrig: begin
        if (tick && (timer_q == TmW'(TRIG_US - 1))) begin
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        if (echo_rise) begin
          state_d = StMeasure;
        end else if (tick && (timer_q == TmW'(ECHO_TIMEOUT_US - 1))) begin
          state_d = StStore;
          cm_d    = DIST_TIMEOUT;
          to_d    = 1'b1;
        end
      end
      StMeasure: begin
        // The tick of the fall-detect cycle is counted so the width matches the echo pulse.
        if (tick) begin
          if (sub_q == SbW'(US_PER_CM - 1)) begin
            sub_d = '0;
            if (cm_q != DIST_TIMEOUT) begin
              cm_d = cm_q + DIST_W'(1);
            end
          end else begin
            sub_d = sub_q + SbW'(1);
          end
        end
        // Timeout wins over a fall in the same cycle: an echo of the full window is too long.
        if (tick && (timer_q == TmW'(ECHO_TIMEOUT_US - 1))) begin
          state_d = StStore;
          cm_d    = DIST_TIMEOUT;
          to_d    = 1'b1;
        end else if (echo_fall) begin
          state_d = StStore;
        end
      end
      StStore: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Prescaler, per-state µs timer and trig-to-trig period counter.
  always_comb begin
    state_change = (state_d != state_q);
    presc_d      = (state_change || tick) ? '0 : presc_q + PcW'(1);
    timer_d      = timer_q;
    if (state_change) begin
      timer_d = '0;
    end else if (tick && (state_q != StIdle) && (timer_q != '1)) begin
      timer_d = timer_q + TmW'(1);
    end
    period_d = period_q;
    if ((state_q == StIdle) && (state_d == StTrig)) begin
      period_d = '0;
    end else if (tick && (period_q != PrW'(PERIOD_US - 1))) begin
      period_d = period_q + PrW'(1);
    end
  end

  // Sequencer state and counters; the period counter starts saturated so enable fires at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      timer_q  <= '0;
      period_q <= PrW'(PERIOD_US - 1);
      sub_q    <= '0;
      cm_q     <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
      to_q     <= to_d;
    end
  end

  // Registered outputs; newest/oldest/valid all change on the edge that enters STORE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q    <= 1'b0;
      newest_q  <= '0;
      oldest_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      trig_q    <= (state_d == StTrig);
      valid_q   <= store_en;
      timeout_q <= store_en & to_d;
      if (store_en) begin
        newest_q <= cm_d;
        oldest_q <= evicted;
      end
    end
  end

  dist_ring_buffer #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .wr_i     (store_en),
    .data_i   (cm_d),
    .evicted_o(evicted),
    .full_o   (full)
  );

endmodule
